beta_recursion_unit: RTL and testbench

- Parametrised successor of the 8-state beta termination block for the LTE turbo (max-log-MAP) decoder; performs a full backward add-compare-select (ACS) recursion over a block or window of trellis steps.
- Selectable initialisation: terminated, equiprobable, or loaded from a bus.
- Per-step normalisation to state 0 with symmetric saturation.
- Valid/ready input stream and output backpressure; feeds the LLR/extrinsic stage.

---
 rtl/turbo_pkg.sv | 42 ++++
 rtl/beta_acs.sv | 19 +
 rtl/beta_recursion_unit.sv | 124 ++++++++++++
 tb/tb_beta_recursion_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo decoder backward recursion: trellis tables,
// init-mode encodings and metric helpers.
package turbo_pkg;

    localparam int NUM_STATES = 8;

    typedef enum logic [1:0] {
        INIT_TERM = 2'd0,
        INIT_EQUI = 2'd1,
        INIT_LOAD = 2'd2,
        INIT_RSVD = 2'd3
    } init_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Branch index: 0 = m00, 1 = m01, 2 = m10, 3 = m11 (x, z bit pair).
    localparam int PRED_A [NUM_STATES] = '{0, 4, 5, 1, 2, 6, 7, 3};
    localparam int PRED_B [NUM_STATES] = '{4, 0, 1, 5, 6, 2, 3, 7};
    localparam int BR_A   [NUM_STATES] = '{0, 0, 1, 1, 1, 1, 0, 0};
    localparam int BR_B   [NUM_STATES] = '{3, 3, 2, 2, 2, 2, 3, 3};

    // Metric used for states known to be unreachable at a terminated block end.
    function automatic logic signed [63:0] neg_init(input int w);
        return -(64'sd1 <<< (w - 2));
    endfunction

    // Clip to the symmetric w-bit range so the most-negative code never appears.
    function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v, input int w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (v > lim)
            return lim;
        if (v < -lim)
            return -lim;
        return v;
    endfunction

endpackage

// File: rtl/beta_acs.sv
// One add-compare-select cell: two candidate path metrics, keeps the larger.
// Ties resolve to path A.
module beta_acs #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_beta,
    input  logic signed [W-1:0] a_br,
    input  logic signed [W-1:0] b_beta,
    input  logic signed [W-1:0] b_br,
    output logic signed [W:0]   sel
);
    logic signed [W:0] sum_a;
    logic signed [W:0] sum_b;

    assign sum_a = {a_beta[W-1], a_beta} + {a_br[W-1], a_br};
    assign sum_b = {b_beta[W-1], b_beta} + {b_br[W-1], b_br};
    assign sel   = (sum_b > sum_a) ? sum_b : sum_a;

endmodule

// File: rtl/beta_recursion_unit.sv
// Backward ACS recursion over a block of trellis steps, one step per accepted input.
// One-cycle latency; stalls input while an unaccepted result is held on beta_out.
module beta_recursion_unit
    import turbo_pkg::*;
#(
    parameter int W     = 16,
    parameter int LEN_W = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                init_mode,
    input  logic [LEN_W-1:0]          blk_len,
    input  logic [NUM_STATES*W-1:0]   beta_init,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [W-1:0]       m00,
    input  logic signed [W-1:0]       m01,
    input  logic signed [W-1:0]       m10,
    input  logic signed [W-1:0]       m11,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_STATES*W-1:0]   beta_out,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);
    fsm_e                state;
    logic signed [W-1:0] beta_q  [NUM_STATES];
    logic signed [W-1:0] bm      [4];
    logic signed [W:0]   acs_new [NUM_STATES];
    logic signed [W-1:0] norm    [NUM_STATES];
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [LEN_W-1:0]    len_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                fire;

    assign bm[0] = m00;
    assign bm[1] = m01;
    assign bm[2] = m10;
    assign bm[3] = m11;

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        logic signed [W+1:0] diff;

        beta_acs #(.W(W)) u_acs (
            .a_beta (beta_q[PRED_A[s]]),
            .a_br   (bm[BR_A[s]]),
            .b_beta (beta_q[PRED_B[s]]),
            .b_br   (bm[BR_B[s]]),
            .sel    (acs_new[s])
        );

        // Re-reference to state 0 so metrics stay bounded across long blocks.
        assign diff    = {acs_new[s][W], acs_new[s]} - {acs_new[0][W], acs_new[0]};
        assign norm[s] = W'(sat_sym(64'(diff), W));
    end

    // Once every step has fired, no further input is taken while the last result drains.
    assign in_ready = (state == ST_RUN) && (cnt != len_q) && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;
    assign cnt_nxt  = cnt + LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++)
                beta_q[s] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q       <= blk_len;
                        cnt         <= '0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        for (int s = 0; s < NUM_STATES; s++) begin
                            case (init_mode_e'(init_mode))
                                INIT_TERM: beta_q[s] <= (s == 0) ? '0 : W'(neg_init(W));
                                INIT_LOAD: beta_q[s] <= beta_init[s*W +: W];
                                default:   beta_q[s] <= '0;
                            endcase
                        end
                        state <= (blk_len != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        for (int s = 0; s < NUM_STATES; s++)
                            beta_q[s] <= norm[s];
                        cnt         <= cnt_nxt;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (cnt_nxt == len_q);
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    if (out_valid_q && out_ready && out_last_q)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        beta_out = '0;
        for (int s = 0; s < NUM_STATES; s++)
            beta_out[s*W +: W] = beta_q[s];
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_beta_recursion_unit.sv
// Directed bench for beta_recursion_unit (W=16): init modes, ACS/saturation,
// backpressure, mid-block reset and zero-length blocks.
module tb_beta_recursion_unit;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [1:0]         init_mode;
    logic [12:0]        blk_len;
    logic [127:0]       beta_init;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] m00, m01, m10, m11;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       beta_out;
    logic               out_last;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int xfer0;
    logic [127:0] exp_v;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (out_valid && out_ready)
            xfers <= xfers + 1;

    beta_recursion_unit #(.W(16), .LEN_W(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .init_mode (init_mode),
        .blk_len   (blk_len),
        .beta_init (beta_init),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m00       (m00),
        .m01       (m01),
        .m10       (m10),
        .m11       (m11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beta_out  (beta_out),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [127:0] pack8(input int v0, input int v1, input int v2, input int v3,
                                           input int v4, input int v5, input int v6, input int v7);
        int v [8];
        logic [127:0] r;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        v[4] = v4; v[5] = v5; v[6] = v6; v[7] = v7;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i*16 +: 16] = v[i][15:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int a, input int b, input int c, input int d);
        m00 = 16'(a); m01 = 16'(b); m10 = 16'(c); m11 = 16'(d);
    endtask

    task automatic begin_blk(input logic [1:0] mode, input int len);
        init_mode = mode;
        blk_len   = 13'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        init_mode = 2'd0; blk_len = 13'd5; beta_init = '0;
        set_m(7, 7, 7, 7);

        // Reset held with stimulus active
        repeat (3) tick();
        chk("rst_beta",      beta_out,  '0);
        chk("rst_out_valid", out_valid, '0);
        chk("rst_in_ready",  in_ready,  '0);
        chk("rst_busy",      busy,      '0);
        chk("rst_done",      done,      '0);
        chk("rst_out_last",  out_last,  '0);
        start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
        tick();

        // Mode 0, terminated, zero metrics, output stalled one cycle
        set_m(0, 0, 0, 0);
        begin_blk(2'd0, 1);
        chk("m0_busy",     busy,     1'b1);
        chk("m0_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("m0_valid", out_valid, 1'b1);
        chk("m0_beta",  beta_out,
            pack8(0, 0, -16384, -16384, -16384, -16384, -16384, -16384));
        chk("m0_last",  out_last, 1'b1);
        chk("m0_stall_in_ready", in_ready, 1'b0);
        chk("m0_no_done_early",  done, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("m0_done",       done,      1'b1);
        chk("m0_done_valid", out_valid, 1'b0);
        chk("m0_done_busy",  busy,      1'b0);
        tick();
        chk("m0_done_pulse", done, 1'b0);

        // Mode 1, equiprobable
        set_m(10, -5, 2, 3);
        begin_blk(2'd1, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("m1_beta", beta_out, pack8(0, 0, -8, -8, -8, -8, 0, 0));
        chk("m1_last", out_last, 1'b1);
        tick();
        chk("m1_done", done, 1'b1);
        tick();

        // Mode 2, loaded zeros, saturation to +32767
        beta_init = '0;
        set_m(-32767, 32767, 32767, -32767);
        begin_blk(2'd2, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("m2_sat_beta", beta_out, pack8(0, 0, 32767, 32767, 32767, 32767, 0, 0));
        tick(); tick();

        // Mode 2, nonzero load actually reaches the recursion
        beta_init = pack8(0, 0, 0, 0, 100, 0, 0, 0);
        set_m(0, 0, 0, 0);
        begin_blk(2'd2, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("m2_load_beta", beta_out, pack8(0, 0, -100, -100, -100, -100, -100, -100));
        tick(); tick();

        // Mode 3 behaves as equiprobable, ignoring beta_init
        begin_blk(2'd3, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("m3_beta", beta_out, '0);
        tick(); tick();

        // Backpressure across a 4-step block
        set_m(10, -5, 2, 3);
        out_ready = 1'b1;
        begin_blk(2'd1, 4);
        xfer0 = xfers;
        in_valid = 1'b1;
        tick();
        chk("bp_s1_beta", beta_out, pack8(0, 0, -8, -8, -8, -8, 0, 0));
        chk("bp_s1_last", out_last, 1'b0);
        tick();
        exp_v = pack8(0, -7, -8, -15, -8, -15, 0, -7);
        chk("bp_s2_beta", beta_out, exp_v);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_beta",  beta_out,  exp_v);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready,  1'b0);
            chk("bp_hold_last",  out_last,  1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_s3_last", out_last, 1'b0);
        chk("bp_s3_new",  (beta_out !== exp_v), 1'b1);
        tick();
        chk("bp_s4_last", out_last, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("bp_done",  done,          1'b1);
        chk("bp_count", xfers - xfer0, 4);
        tick();

        // Reset at step 5 of 10
        begin_blk(2'd1, 10);
        in_valid = 1'b1;
        repeat (5) tick();
        chk("mid_s5_valid", out_valid, 1'b1);
        chk("mid_s5_last",  out_last,  1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_beta",  beta_out,  '0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy",  busy,      1'b0);
        chk("mid_rst_ready", in_ready,  1'b0);
        chk("mid_rst_done",  done,      1'b0);
        in_valid = 1'b0;
        tick();
        chk("mid_rst_no_done", done, 1'b0);
        rst_n = 1'b1;
        #2;

        // Zero-length block goes straight to done
        begin_blk(2'd0, 0);
        chk("len0_done",  done,      1'b1);
        chk("len0_valid", out_valid, 1'b0);
        chk("len0_busy",  busy,      1'b0);
        tick();
        chk("len0_done_pulse", done,      1'b0);
        chk("len0_no_valid",   out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
